// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter and its run-end detector benches.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_GAP_LEN = 2;

  // {previous bit, current bit} that ends a run of ones; the detector fires Y on it.
  localparam logic [1:0] RUN_END = 2'b10;

  function automatic logic is_run_end(input logic prev_bit, input logic cur_bit);
    return {prev_bit, cur_bit} == RUN_END;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/stream bundle between a pattern source and the transmitter.
interface seq_pattern_tx_if import seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RPT_W = 4,
  parameter int FC_W  = 8
);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [RPT_W-1:0] repeat_n;
  logic             ready;
  logic             x_out;
  logic             x_valid;
  logic             done;
  logic [FC_W-1:0]  fall_cnt;

  modport master (
    output start, pattern, repeat_n,
    input  ready, x_out, x_valid, done, fall_cnt
  );

  modport slave (
    input  start, pattern, repeat_n,
    output ready, x_out, x_valid, done, fall_cnt
  );

endinterface

// File: rtl/seq_pattern_tx_fall_counter.sv
// Counts 1->0 transitions on a qualified bit stream, saturating at all-ones.
module fall_counter import seq_pkg::*; #(
  parameter int FC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            valid,
  input  logic            bit_in,
  output logic [FC_W-1:0] cnt
);

  localparam logic [FC_W-1:0] CNT_MAX = '1;

  logic            prev_reg;
  logic [FC_W-1:0] cnt_reg;

  // prev restarts at 0 on clear, so a leading 0 never counts as a fall.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (valid) begin
      if (is_run_end(prev_reg, bit_in) && (cnt_reg != CNT_MAX))
        cnt_reg <= cnt_reg + FC_W'(1);
      prev_reg <= bit_in;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/seq_pattern_tx.sv
// Emits a parallel-loaded pattern MSB-first repeat_n times, each followed by GAP_LEN zeros,
// and counts the falling edges it sends.
module seq_pattern_tx import seq_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int GAP_LEN = DEF_GAP_LEN,
  parameter int RPT_W   = 4,
  parameter int FC_W    = 8
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave bus
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GC_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_LEN - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [RPT_W-1:0] rpt_left_reg, rpt_left_next;
  logic [BC_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [GC_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic             x_out_reg, x_out_next;
  logic             x_valid_reg, x_valid_next;
  logic             done_reg, done_next;
  logic             ready_reg, ready_next;
  logic             fc_clear;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      rpt_left_reg <= '0;
      bit_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      x_out_reg    <= 1'b0;
      x_valid_reg  <= 1'b0;
      done_reg     <= 1'b0;
      ready_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      rpt_left_reg <= rpt_left_next;
      bit_cnt_reg  <= bit_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      x_out_reg    <= x_out_next;
      x_valid_reg  <= x_valid_next;
      done_reg     <= done_next;
      ready_reg    <= ready_next;
    end
  end

  // The shift register rotates rather than shifts, so after WIDTH bits it holds
  // the original pattern again and the next repetition needs no reload.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    rpt_left_next = rpt_left_reg;
    bit_cnt_next  = bit_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    x_out_next    = 1'b0;
    x_valid_next  = 1'b0;
    done_next     = 1'b0;
    fc_clear      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          fc_clear = 1'b1;
          if (bus.repeat_n != '0) begin
            shift_next    = rotl(bus.pattern);
            rpt_left_next = bus.repeat_n;
            bit_cnt_next  = '0;
            gap_cnt_next  = '0;
            x_out_next    = bus.pattern[WIDTH-1];
            x_valid_next  = 1'b1;
            state_next    = SHIFT;
          end else begin
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end

      SHIFT: begin
        x_valid_next = 1'b1;
        if (bit_cnt_reg == BC_LAST) begin
          gap_cnt_next = '0;
          state_next   = GAP;
        end else begin
          x_out_next   = shift_reg[WIDTH-1];
          shift_next   = rotl(shift_reg);
          bit_cnt_next = bit_cnt_reg + BC_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt_reg == GC_LAST) begin
          if (rpt_left_reg > RPT_W'(1)) begin
            rpt_left_next = rpt_left_reg - RPT_W'(1);
            bit_cnt_next  = '0;
            x_out_next    = shift_reg[WIDTH-1];
            shift_next    = rotl(shift_reg);
            x_valid_next  = 1'b1;
            state_next    = SHIFT;
          end else begin
            done_next  = 1'b1;
            state_next = DONE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + GC_W'(1);
          x_valid_next = 1'b1;
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase

    ready_next = (state_next == IDLE);
  end

  // Counts the bits as they appear on x_out, so the final gap bit lands in fall_cnt by the done cycle.
  fall_counter #(.FC_W(FC_W)) u_fall_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (fc_clear),
    .valid  (x_valid_reg),
    .bit_in (x_out_reg),
    .cnt    (bus.fall_cnt)
  );

  assign bus.ready   = ready_reg;
  assign bus.x_out   = x_out_reg;
  assign bus.x_valid = x_valid_reg;
  assign bus.done    = done_reg;

endmodule
